uart_tx_gen: RTL and testbench
==============================

Name: uart_tx_gen

Overview:
- Parametrised next-generation UART transmitter for the CoreUART family. It serialises one character per valid/ready handshake onto `tx`.
- Runs entirely on the system clock, qualified by an oversampled baud tick. Frame format is runtime-configurable: 5..DATA_W data bits, five parity modes, and 1, 1.5 or 2 stop bits.
- Adds line-break generation with guaranteed mark-after-break recovery. Sits between the TX FIFO (or holding register) and the pad.

Parameters:
- DATA_W, 9: maximum data bits per character; legal 5..9.
- OVS, 16: baud ticks per bit period; even, 4..64.

Ports:
- clk  input  1  system clock
- aresetn  input  1  reset, asynchronous, active-low; clock clk
- baud_tick  input  1  one-clk pulse at OVS x baud rate
- cfg_data_bits  input  4  data bits per character (5..9)
- cfg_parity  input  3  0 none, 1 even, 2 odd, 3 mark (1), 4 space (0); 5-7 treated as none
- cfg_stop  input  2  0 = 1 stop, 1 = 1.5 stop, 2/3 = 2 stop
- cfg_break  input  1  level request: hold line low
- s_valid  input  1  character available
- s_data  input  DATA_W  character, LSB transmitted first
- s_ready  output  1  block can accept a character this cycle
- tx  output  1  serial line, idle high
- busy  output  1  frame or break in progress
- done  output  1  one-clk pulse at end of final stop bit

Behaviour:
- Reset: async, all state cleared. Reset values: tx=1, s_ready=0 during reset, busy=0, done=0, state IDLE, counters 0.
  - s_ready rises on the first clk after reset release if cfg_break=0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- s_ready = (state==IDLE) & ~cfg_break.
- Accept when s_valid & s_ready. On accept, capture s_data, cfg_data_bits, cfg_parity and cfg_stop. Config changes mid-frame have no effect on that frame.
- Data-bit clamp: captured cfg_data_bits < 5 is clamped to 5; > DATA_W is clamped to DATA_W.
- Tick counter: width clog2(OVS). Increments only on baud_tick. A bit ends on the baud_tick where the counter reaches its terminal count; the counter then resets to 0.
- States and transitions:
  - IDLE: tx=1. Accept -> START. cfg_break=1 -> BREAK.
  - START: tx=0 for OVS ticks -> DATA. START is entered on the clk after accept, so tx falls on the clk after accept.
  - DATA: tx=shift_reg[0], shift right each bit. Bit counter runs 0..nbits-1. After the last bit: parity enabled -> PARITY, else STOP.
  - PARITY: OVS ticks -> STOP. Value is:
    - even: XOR of used data bits;
    - odd: inverse of that XOR;
    - mark: 1;
    - space: 0.
    - Only the nbits used data bits enter the XOR; unused upper s_data bits are ignored.
  - STOP: tx=1 for OVS ticks (1 stop), 3*OVS/2 ticks (1.5 stop) or 2*OVS ticks (2 stop). On the final tick: done=1 for one clk, -> IDLE.
  - BREAK: tx=0 while cfg_break=1. On cfg_break falling -> MAB.
  - MAB: tx=1 for OVS ticks -> IDLE.
- cfg_break asserted mid-frame is ignored until the frame completes. If cfg_break=1 when STOP completes, go IDLE then BREAK next clk; no character is accepted in between.
- busy = (state != IDLE).
- Back-to-back frames:
  - s_ready reasserts the clk after done.
  - The inter-frame gap is 1 clk beyond the stop time (no extra baud tick).
- baud_tick coincident with accept: that tick is not counted toward START.
- baud_tick held high continuously is legal: each clk counts as one tick.

Test Plan:
- Basic frame: OVS=16, 8N1, s_data=0x55, accept -> tx = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each bit exactly 16 baud_ticks; done pulses once; busy low 1 clk later.
- Odd parity with 7 data bits: 7O2, s_data=0x83 (bit7 ignored) -> data 1100000, parity=1, stop held 32 ticks; total 10 bits + 1 extra stop = 176 ticks.
- 1.5 stop and width clamp: DATA_W=9, cfg_data_bits=12, cfg_stop=1, s_data=0x1FF -> 9 data ones transmitted; stop high 24 ticks; cfg_data_bits=3 sends 5 bits.
- Mid-frame config change: change cfg_parity and cfg_data_bits during DATA -> current frame unchanged; next frame uses the new values.
- Break: assert cfg_break for 500 ticks in idle -> tx=0, s_ready=0; deassert -> tx=1 for exactly 16 ticks before s_ready=1. Break requested mid-frame starts only after done.
- Reset mid-frame: drop aresetn during DATA -> tx=1 asynchronously, busy=0; after release, a new 0xA5 frame transmits correctly.

Source files
------------

// File: rtl/uart_tx_gen.sv
// UART transmitter: one character per valid/ready handshake, runtime frame format,
// oversampled baud-tick timing and line-break generation with mark-after-break.
module uart_tx_gen #(
   parameter int DATA_W = 9,
   parameter int OVS    = 16
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              baud_tick,
   input  logic [3:0]        cfg_data_bits,
   input  logic [2:0]        cfg_parity,
   input  logic [1:0]        cfg_stop,
   input  logic              cfg_break,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
   localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(OVS - 1);
   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(OVS / 2 - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] BREAK  = 3'd5;
   localparam logic [2:0] MAB    = 3'd6;

   logic [2:0]        state;
   logic [CNT_W-1:0]  tick_cnt;
   logic [3:0]        bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic [3:0]        nbits;
   logic              par_en;
   logic              par_bit;
   logic [2:0]        stop_halves;
   logic              out_of_reset;

   logic [3:0]        nbits_in;
   logic [DATA_W-1:0] used_mask;
   logic              par_in;
   logic              par_en_in;
   logic [2:0]        stop_halves_in;
   logic              accept;
   logic              tick_tc;
   logic              stop_last;

   // Frame format is resolved at accept time; parity only covers the bits actually sent.
   always_comb begin
      nbits_in = cfg_data_bits;
      if (cfg_data_bits < 4'd5)
         nbits_in = 4'd5;
      else if (cfg_data_bits > 4'(DATA_W))
         nbits_in = 4'(DATA_W);
      used_mask = '0;
      for (int i = 0; i < DATA_W; i++)
         used_mask[i] = (4'(i) < nbits_in);
      par_in    = 1'b0;
      par_en_in = 1'b1;
      case (cfg_parity)
         3'd1:    par_in = ^(s_data & used_mask);
         3'd2:    par_in = ~^(s_data & used_mask);
         3'd3:    par_in = 1'b1;
         3'd4:    par_in = 1'b0;
         default: par_en_in = 1'b0;
      endcase
      case (cfg_stop)
         2'd0:    stop_halves_in = 3'd2;
         2'd1:    stop_halves_in = 3'd3;
         default: stop_halves_in = 3'd4;
      endcase
   end

   // Stop time is counted in half-bit units so 1.5 stop bits fit the same tick counter.
   assign tick_tc   = baud_tick & (tick_cnt == ((state == STOP) ? HALF_TC : BIT_TC));
   assign stop_last = (bit_cnt == ({1'b0, stop_halves} - 4'd1));
   assign s_ready   = out_of_reset & (state == IDLE) & ~cfg_break;
   assign accept    = s_valid & s_ready;
   assign busy      = (state != IDLE);
   assign done      = (state == STOP) & tick_tc & stop_last;

   always_comb begin
      case (state)
         START, BREAK: tx = 1'b0;
         DATA:         tx = shift_reg[0];
         PARITY:       tx = par_bit;
         default:      tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         nbits        <= '0;
         par_en       <= 1'b0;
         par_bit      <= 1'b0;
         stop_halves  <= '0;
         out_of_reset <= 1'b0;
      end else begin
         out_of_reset <= 1'b1;
         if (baud_tick && state != IDLE && state != BREAK)
            tick_cnt <= tick_tc ? '0 : tick_cnt + CNT_W'(1);
         case (state)
            IDLE: begin
               if (accept) begin
                  state       <= START;
                  shift_reg   <= s_data;
                  nbits       <= nbits_in;
                  par_en      <= par_en_in;
                  par_bit     <= par_in;
                  stop_halves <= stop_halves_in;
               end else if (cfg_break) begin
                  state <= BREAK;
               end
            end
            START: if (tick_tc) begin
               state   <= DATA;
               bit_cnt <= '0;
            end
            DATA: if (tick_tc) begin
               shift_reg <= shift_reg >> 1;
               if (bit_cnt == nbits - 4'd1) begin
                  bit_cnt <= '0;
                  state   <= par_en ? PARITY : STOP;
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            PARITY: if (tick_tc) state <= STOP;
            STOP: if (tick_tc) begin
               if (stop_last) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
            BREAK: if (!cfg_break) state <= MAB;
            MAB: if (tick_tc) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: randomized baud ticks and frames compared against
// a per-tick waveform model built from the frame-format rules.
module tb_uart_tx_gen;

   localparam int DATA_W = 9;
   localparam int OVS    = 16;

   logic              clk = 1'b0;
   logic              aresetn = 1'b0;
   logic              baud_tick = 1'b0;
   logic [3:0]        cfg_data_bits = 4'd8;
   logic [2:0]        cfg_parity = 3'd0;
   logic [1:0]        cfg_stop = 2'd0;
   logic              cfg_break = 1'b0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic              tx;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;
   int tick_pct = 40;
   bit exp_q[$];

   uart_tx_gen #(.DATA_W(DATA_W), .OVS(OVS)) dut (
      .clk(clk), .aresetn(aresetn), .baud_tick(baud_tick),
      .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
      .cfg_break(cfg_break), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic rand_tick();
      if (tick_pct >= 100) return 1'b1;
      return logic'(int'($urandom_range(99)) < tick_pct);
   endfunction

   // Expected line level for every baud tick of a frame, start bit through last stop tick.
   task automatic build_expected(input logic [DATA_W-1:0] d, input int bits, input int par, input int stop);
      int n;
      int ones;
      bit pbit;
      int stop_ticks;
      n = (bits < 5) ? 5 : ((bits > DATA_W) ? DATA_W : bits);
      exp_q.delete();
      repeat (OVS) exp_q.push_back(1'b0);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         repeat (OVS) exp_q.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (par >= 1 && par <= 4) begin
         case (par)
            1:       pbit = (ones % 2) == 1;
            2:       pbit = (ones % 2) == 0;
            3:       pbit = 1'b1;
            default: pbit = 1'b0;
         endcase
         repeat (OVS) exp_q.push_back(pbit);
      end
      stop_ticks = (stop == 0) ? OVS : ((stop == 1) ? 3 * OVS / 2 : 2 * OVS);
      repeat (stop_ticks) exp_q.push_back(1'b1);
   endtask

   // Offers one character, then follows the frame tick by tick and reports what it saw.
   task automatic run_frame(input logic [DATA_W-1:0] d, input logic [3:0] bits, input logic [2:0] par,
                            input logic [1:0] stop, input bit scramble, input bit brk_mid,
                            output bit acc_ok, output int wait_cyc, output bit idle_ok,
                            output int bad_cnt, output int first_bad, output int done_cnt);
      int idx;
      logic dn_exp;
      acc_ok = 0; wait_cyc = 0; idle_ok = 0; bad_cnt = 0; first_bad = -1; done_cnt = 0;
      build_expected(d, int'(bits), int'(par), int'(stop));
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = d; cfg_data_bits = bits; cfg_parity = par; cfg_stop = stop;
         cfg_break = 1'b0; baud_tick = rand_tick();
         #1;
         if (s_ready === 1'b1) begin
            acc_ok  = 1;
            idle_ok = (busy === 1'b0) && (tx === 1'b1);
            break;
         end
         wait_cyc++;
      end
      if (!acc_ok) begin
         s_valid = 1'b0;
         return;
      end
      idx = 0;
      for (int cyc = 0; cyc < 20000 && idx < int'(exp_q.size()); cyc++) begin
         @(negedge clk);
         s_valid = logic'($urandom_range(1)) && (idx + OVS < int'(exp_q.size()));
         s_data  = DATA_W'($urandom);
         if (scramble) begin
            cfg_data_bits = 4'($urandom_range(15));
            cfg_parity    = 3'($urandom_range(7));
            cfg_stop      = 2'($urandom_range(3));
         end
         cfg_break = brk_mid && (idx > OVS);
         baud_tick = rand_tick();
         #1;
         if (tx !== exp_q[idx] || busy !== 1'b1 || s_ready !== 1'b0) begin
            bad_cnt++;
            if (first_bad < 0) first_bad = idx;
         end
         dn_exp = baud_tick && (idx == int'(exp_q.size()) - 1);
         if (done !== dn_exp) begin
            bad_cnt++;
            if (first_bad < 0) first_bad = idx;
         end
         if (done === 1'b1) done_cnt++;
         if (baud_tick) idx++;
      end
      if (idx != int'(exp_q.size())) begin
         bad_cnt++;
         if (first_bad < 0) first_bad = idx;
      end
      s_valid = 1'b0;
   endtask

   task automatic test_reset;
      aresetn = 1'b0; s_valid = 1'b0; cfg_break = 1'b0; baud_tick = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", s_ready); end
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_ready_early: got %b want 0", s_ready); end
      @(negedge clk);
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b want 1", s_ready); end
   endtask

   task automatic test_basic;
      bit acc, idl;
      int wc, bad, fb, dc;
      tick_pct = 40;
      run_frame(9'h055, 4'd8, 3'd0, 2'd0, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (!acc) begin errors++; $display("[TB] FAIL basic_accept: got 0 want 1"); end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL basic_wave: %0d bad cycles (first tick %0d) want 0", bad, fb); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL basic_done: %0d pulses want 1", dc); end
      @(negedge clk);
      baud_tick = rand_tick();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_after: got %b want 0", busy); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_after: got %b want 1", s_ready); end
   endtask

   task automatic test_odd_parity;
      bit acc, idl;
      int wc, bad, fb, dc;
      tick_pct = 100;
      run_frame(9'h083, 4'd7, 3'd2, 2'd2, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (!acc) begin errors++; $display("[TB] FAIL odd7_accept: got 0 want 1"); end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL odd7_wave: %0d bad cycles (first tick %0d) want 0", bad, fb); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL odd7_done: %0d pulses want 1", dc); end
   endtask

   task automatic test_clamp;
      bit acc, idl;
      int wc, bad, fb, dc;
      tick_pct = 50;
      run_frame(9'h1FF, 4'd12, 3'd0, 2'd1, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (!acc) begin errors++; $display("[TB] FAIL clamp_hi_accept: got 0 want 1"); end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL clamp_hi_wave: %0d bad cycles (first tick %0d) want 0", bad, fb); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL clamp_hi_done: %0d pulses want 1", dc); end
      run_frame(9'h1B6, 4'd3, 3'd1, 2'd0, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (!acc) begin errors++; $display("[TB] FAIL clamp_lo_accept: got 0 want 1"); end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL clamp_lo_wave: %0d bad cycles (first tick %0d) want 0", bad, fb); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL clamp_lo_done: %0d pulses want 1", dc); end
   endtask

   task automatic test_config_change;
      bit acc, idl;
      int wc, bad, fb, dc;
      tick_pct = 60;
      run_frame(9'h0C9, 4'd8, 3'd1, 2'd0, 1, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (bad != 0 || !acc) begin errors++; $display("[TB] FAIL cfgchg_first_wave: %0d bad cycles (first tick %0d) acc %0d want 0", bad, fb, acc); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL cfgchg_first_done: %0d pulses want 1", dc); end
      run_frame(9'h13A, 4'd6, 3'd4, 2'd3, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (bad != 0 || !acc) begin errors++; $display("[TB] FAIL cfgchg_next_wave: %0d bad cycles (first tick %0d) acc %0d want 0", bad, fb, acc); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL cfgchg_next_done: %0d pulses want 1", dc); end
   endtask

   task automatic test_back_to_back;
      bit acc, idl;
      int wc, bad, fb, dc;
      tick_pct = 100;
      run_frame(9'h0F0, 4'd8, 3'd3, 2'd0, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (bad != 0 || !acc) begin errors++; $display("[TB] FAIL b2b_first_wave: %0d bad cycles (first tick %0d) acc %0d want 0", bad, fb, acc); end
      run_frame(9'h00F, 4'd5, 3'd0, 2'd0, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (wc != 0) begin errors++; $display("[TB] FAIL b2b_gap: waited %0d extra clks want 0", wc); end
      checks++; if (!idl) begin errors++; $display("[TB] FAIL b2b_idle_cycle: busy %b tx %b want busy 0 tx 1", busy, tx); end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b2b_second_wave: %0d bad cycles (first tick %0d) want 0", bad, fb); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL b2b_second_done: %0d pulses want 1", dc); end
   endtask

   // Waits for the mark-after-break and returns how many ticks tx stayed high before s_ready.
   task automatic drain_mab(output int mab_ticks, output bit reached, output bit mark_bad);
      mab_ticks = 0; reached = 0; mark_bad = 0;
      @(negedge clk);
      cfg_break = 1'b0; s_valid = 1'b0; baud_tick = rand_tick();
      #1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         baud_tick = rand_tick();
         #1;
         if (s_ready === 1'b1) begin
            reached = 1;
            break;
         end
         if (tx !== 1'b1) mark_bad = 1;
         if (baud_tick) mab_ticks++;
      end
   endtask

   task automatic test_break;
      int ticks, mab;
      bit bad, reached, mbad;
      tick_pct = 50;
      @(negedge clk);
      cfg_break = 1'b1; s_valid = 1'b1; s_data = 9'h0AA; baud_tick = rand_tick();
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL break_ready_req: got %b want 0", s_ready); end
      ticks = 0; bad = 0;
      for (int c = 0; c < 5000 && ticks < 500; c++) begin
         @(negedge clk);
         baud_tick = rand_tick();
         #1;
         if (tx !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) bad = 1;
         if (baud_tick) ticks++;
      end
      checks++; if (bad) begin errors++; $display("[TB] FAIL break_hold: tx %b ready %b busy %b want 0 0 1", tx, s_ready, busy); end
      drain_mab(mab, reached, mbad);
      checks++; if (!reached) begin errors++; $display("[TB] FAIL break_mab_timeout: s_ready never returned"); end
      checks++; if (mab != OVS || mbad) begin errors++; $display("[TB] FAIL break_mab: %0d high ticks (glitch %0d) want %0d", mab, mbad, OVS); end
   endtask

   task automatic test_break_mid;
      bit acc, idl, reached, mbad;
      int wc, bad, fb, dc, mab;
      tick_pct = 70;
      run_frame(9'h05A, 4'd8, 3'd1, 2'd0, 0, 1, acc, wc, idl, bad, fb, dc);
      checks++; if (bad != 0 || !acc || dc != 1) begin errors++; $display("[TB] FAIL brkmid_frame: %0d bad cycles (first tick %0d) done %0d want 0 bad 1 done", bad, fb, dc); end
      @(negedge clk);
      s_valid = 1'b1; s_data = 9'h111; baud_tick = rand_tick();
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL brkmid_idle: tx %b busy %b ready %b want 1 0 0", tx, busy, s_ready); end
      @(negedge clk);
      baud_tick = rand_tick();
      #1;
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL brkmid_break: tx %b busy %b want 0 1", tx, busy); end
      drain_mab(mab, reached, mbad);
      checks++; if (!reached || mab != OVS || mbad) begin errors++; $display("[TB] FAIL brkmid_mab: %0d high ticks reached %0d glitch %0d want %0d", mab, reached, mbad, OVS); end
   endtask

   task automatic test_reset_mid;
      bit acc, idl, got;
      int wc, bad, fb, dc;
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = 9'h0F3; cfg_data_bits = 4'd8; cfg_parity = 3'd0;
         cfg_stop = 2'd0; cfg_break = 1'b0; baud_tick = 1'b1;
         #1;
         got = s_ready;
      end
      checks++; if (!got) begin errors++; $display("[TB] FAIL rstmid_accept: got 0 want 1"); end
      @(negedge clk);
      s_valid = 1'b0;
      repeat (OVS + 40) @(negedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b want 1", busy); end
      #2;
      aresetn = 1'b0;
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async: tx %b busy %b ready %b want 1 0 0", tx, busy, s_ready); end
      @(negedge clk);
      aresetn = 1'b1;
      tick_pct = 30;
      run_frame(9'h0A5, 4'd8, 3'd0, 2'd0, 0, 0, acc, wc, idl, bad, fb, dc);
      checks++; if (bad != 0 || !acc) begin errors++; $display("[TB] FAIL rstmid_new_wave: %0d bad cycles (first tick %0d) acc %0d want 0", bad, fb, acc); end
      checks++; if (dc != 1) begin errors++; $display("[TB] FAIL rstmid_new_done: %0d pulses want 1", dc); end
   endtask

   task automatic test_random;
      bit acc, idl;
      int wc, bad, fb, dc;
      logic [DATA_W-1:0] d;
      logic [3:0] nb;
      logic [2:0] pm;
      logic [1:0] sm;
      for (int f = 0; f < 8; f++) begin
         case ($urandom_range(2))
            0:       tick_pct = 100;
            1:       tick_pct = 50;
            default: tick_pct = 25;
         endcase
         d  = DATA_W'($urandom);
         nb = 4'($urandom_range(15));
         pm = 3'($urandom_range(7));
         sm = 2'($urandom_range(3));
         run_frame(d, nb, pm, sm, bit'($urandom_range(1)), 0, acc, wc, idl, bad, fb, dc);
         checks++; if (!acc) begin errors++; $display("[TB] FAIL rand%0d_accept: got 0 want 1", f); end
         checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rand%0d_wave: d=%h bits=%0d par=%0d stop=%0d %0d bad cycles (first tick %0d) want 0", f, d, nb, pm, sm, bad, fb); end
         checks++; if (dc != 1) begin errors++; $display("[TB] FAIL rand%0d_done: %0d pulses want 1", f, dc); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_odd_parity;
      test_clamp;
      test_config_change;
      test_back_to_back;
      test_break;
      test_break_mid;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
